sev_seg_scan: RTL
=================

SEV_SEG_SCAN -- requirements
Module: sev_seg_scan

Interface
REQ-001 SHALL have parameter DIGIT_TICKS, default 100000, clk cycles each digit is lit (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have port clk  input  1  rising-edge system clock; the only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port load  input  1  single-cycle strobe that captures value and dp_in.
REQ-005 SHALL have port value  input  16  four hex nibbles; digit k = value[4k+3:4k], digit 0 rightmost.
REQ-006 SHALL have port dp_in  input  4  decimal-point request per digit, 1 = lit.
REQ-007 SHALL have port an  output  4  digit anodes, active-low, one-hot-low when a digit is lit.
REQ-008 SHALL have port seg  output  7  segments, active-low, gfedcba order.
REQ-009 SHALL have port dp  output  1  decimal point, active-low.
REQ-010 SHALL have port load_ack  output  1  one-cycle pulse when a pending value is committed to the display.

Function
REQ-011 SHALL keep a tick counter 0..DIGIT_TICKS-1; when it wraps, the digit index (2 bits) advances 0->1->2->3->0.
REQ-012 SHALL define the frame boundary as the cycle where the tick counter wraps with digit index 3.
REQ-013 SHALL latch {value, dp_in} into a pending register on load and set pending_valid.
REQ-014 SHALL copy pending into the display register at a frame boundary when pending_valid=1, clear pending_valid, and assert load_ack that same cycle.
REQ-015 SHALL, when load coincides with a frame boundary, commit the new {value, dp_in} directly and pulse load_ack; the older pending contents are discarded.
REQ-016 SHALL, on back-to-back load strobes within a frame, keep only the last; load_ack pulses once per frame at most.
REQ-017 SHALL register an, seg, and dp; they reflect the digit index with exactly one cycle of latency.
REQ-018 SHALL drive seg as the 7-segment pattern of the selected nibble (0->1000000, 8->0000000, F->0001110) and drive dp = ~display_dp[index].
REQ-019 SHALL never light more than one anode in any cycle; no glitch cycle with two anodes low on a digit change.
REQ-020 SHALL keep the display stable mid-frame; a tear (mixed old/new digits within one frame) is forbidden.

Reset
REQ-021 SHALL, while reset=1, drive an=1111, seg=1111111, dp=1, and load_ack=0; clear the tick counter, digit index, display register, pending register, and pending_valid.
REQ-022 SHALL, on the first cycle after reset deasserts, output an=1110 and seg=1000000 (digit 0 showing 0).
REQ-023 SHALL, on reset asserted mid-frame, drop any pending load without acknowledging it.

Configuration
REQ-024 SHALL support macro SEV_SEG_SCAN_LEADING_ZERO_BLANK_EN. When defined, it blanks (an bit held high, seg=1111111, dp=1) any digit above the most significant nonzero digit of the display value unless that digit's dp is set; digit 0 is never blanked. When undefined, all four digits are always lit in turn.

Structure
REQ-025 SHALL place in a shared package sev_seg_pkg the 7-bit blank constant 1111111, the anode-off constant 1111, and the digit-index typedef (2 bits).
REQ-026 SHALL instantiate the existing hex-to-segment decoder sev_seg as the single sub-module, fed by the selected nibble; its output is registered here.

Verification (DIGIT_TICKS=4)
REQ-027 SHALL check: reset release, no load -> an cycles 1110,1101,1011,0111 every 4 clk; seg=1000000 throughout.
REQ-028 SHALL check: load value=16'h1234 mid-frame -> display unchanged until the frame boundary; load_ack pulses once; next frame shows digits 4,3,2,1 (seg 0011001,0110000,0100100,1111001).
REQ-029 SHALL check: load 16'hAAAA then 16'h5555 within one frame -> only 5555 is displayed; exactly one load_ack.
REQ-030 SHALL check: load on the frame-boundary cycle with 16'hF00F -> load_ack that cycle; the following cycle shows an=1110, seg=0001110.
REQ-031 SHALL check: with SEV_SEG_SCAN_LEADING_ZERO_BLANK_EN, value=16'h0007 and dp_in=0 -> only an=1110 ever goes low, with seg=1111000; value=16'h0000 -> digit 0 shows 1000000.
REQ-032 SHALL check: reset during a pending load -> outputs revert to the REQ-021 values; no load_ack; after release the display shows 0000.

Source files
------------

// File: rtl/sev_seg_pkg.sv
// sev_seg_pkg: shared constants and digit-index type for the seven-segment scanner
package sev_seg_pkg;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF = 4'b1111;
    typedef logic [1:0] digit_t;
endpackage

// File: rtl/sev_seg.sv
// sev_seg: hex nibble to active-low seven-segment pattern, gfedcba order
module sev_seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b1111111;
        case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/sev_seg_scan.sv
// sev_seg_scan: tear-free 4-digit multiplexed hex display; SEV_SEG_SCAN_LEADING_ZERO_BLANK_EN blanks leading zeros
module sev_seg_scan
    import sev_seg_pkg::*;
#(
    parameter int DIGIT_TICKS = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        load_ack
);
    localparam int TW = $clog2(DIGIT_TICKS);
    logic [TW-1:0] tick, tick_n;
    digit_t idx, idx_n;
    logic [15:0] disp_val, disp_val_n, pend_val;
    logic [3:0] disp_dp, disp_dp_n, pend_dp, nib;
    logic [6:0] seg_d;
    logic pend_valid, wrap, frame, commit, blank;
    assign wrap = tick == TW'(DIGIT_TICKS - 1);
    assign frame = wrap && idx == 2'd3;
    assign commit = frame && (load || pend_valid);
    assign load_ack = commit && !reset;
    assign tick_n = wrap ? '0 : tick + 1'b1;
    assign idx_n = wrap ? idx + 2'd1 : idx;
    assign disp_val_n = !commit ? disp_val : load ? value : pend_val;
    assign disp_dp_n = !commit ? disp_dp : load ? dp_in : pend_dp;
    assign nib = disp_val_n[{idx_n, 2'b00} +: 4];
`ifdef SEV_SEG_SCAN_LEADING_ZERO_BLANK_EN
    assign blank = idx_n != 2'd0 && (disp_val_n >> {idx_n, 2'b00}) == 16'd0 && !disp_dp_n[idx_n];
`else
    assign blank = 1'b0;
`endif
    sev_seg u_dec (.hex(nib), .seg(seg_d));
    // outputs are built from next-state so a committed frame starts cleanly on digit 0
    always_ff @(posedge clk) begin
        if (reset) begin
            tick <= '0;
            idx <= '0;
            disp_val <= '0;
            disp_dp <= '0;
            pend_val <= '0;
            pend_dp <= '0;
            pend_valid <= 1'b0;
            an <= AN_OFF;
            seg <= SEG_BLANK;
            dp <= 1'b1;
        end else begin
            tick <= tick_n;
            idx <= idx_n;
            disp_val <= disp_val_n;
            disp_dp <= disp_dp_n;
            if (load && !frame) begin
                pend_val <= value;
                pend_dp <= dp_in;
            end
            pend_valid <= !frame && (load || pend_valid);
            an <= blank ? AN_OFF : ~(4'b0001 << idx_n);
            seg <= blank ? SEG_BLANK : seg_d;
            dp <= blank || !disp_dp_n[idx_n];
        end
    end
endmodule
